alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter RF_DEPTH, default 4, number of 8-bit registers; power of 2, at least 2; AW = log2(RF_DEPTH).
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port instr_valid  in  1  instruction offered.
REQ-005 SHALL have port instr  in  1+3*AW  {rd, rs1, rs2, op}; op 0 = add, 1 = shift-left.
REQ-006 SHALL have port instr_ready  out  1  registered; instruction accepted when instr_valid && instr_ready at a rising edge.
REQ-007 SHALL have port load_valid / load_addr / load_data  in  1 / AW / 8  direct register-file write.
REQ-008 SHALL have port load_ready  out  1  load accepted when load_valid && load_ready.
REQ-009 SHALL have port alu_a / alu_b  out  8 / 8  registered operands to the downstream adder/shifter.
REQ-010 SHALL have port alu_op  out  1  registered opcode to the ALU.
REQ-011 SHALL have port alu_result  in  8  combinational ALU result: a+b mod 256 when op=0, a<<b when op=1 (0 for b>=8).
REQ-012 SHALL have port wb_valid / wb_addr / wb_data  out  1 / AW / 8  one-cycle writeback report.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; no other transitions apart from reset.
REQ-014 In IDLE, on accept, SHALL register alu_a=rf[rs1], alu_b=rf[rs2], alu_op=op and rd, clear instr_ready, and go to EXEC.
REQ-015 In EXEC, SHALL capture alu_result into a result register and go to WB.
REQ-016 In WB, SHALL write rf[rd]=result, drive wb_valid=1, wb_addr=rd, wb_data=result, set instr_ready, and go to IDLE.
REQ-017 Timing: accept at edge k; wb_valid is high for exactly the cycle after edge k+2; rf is updated at edge k+3; the next accept is possible at edge k+3; throughput is 1 instruction per 3 cycles.
REQ-018 alu_a, alu_b and alu_op SHALL hold their values from accept until the next accept.
REQ-019 Operand reads at accept SHALL see pre-edge rf contents; a load to rs1/rs2 at the same edge does not forward.
REQ-020 rs1 == rs2 == rd SHALL be legal; rd receives the result.
REQ-021 load_ready SHALL be 0 in WB and 1 otherwise once out of reset, so a load never collides with a writeback; a load in IDLE or EXEC writes at that edge.
REQ-022 A load in EXEC to the in-flight rd SHALL be overwritten by the subsequent WB.
REQ-023 Arithmetic SHALL stay 8-bit; no carry is produced or kept.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, all rf entries 0, alu_a/alu_b/alu_op 0, result 0, wb_valid/wb_addr/wb_data 0, instr_ready 0, load_ready 0.
REQ-025 instr_ready and load_ready SHALL rise at the first rising edge after rst_n deasserts.
REQ-026 Reset during EXEC or WB SHALL abandon the instruction with no rf write and no wb_valid.

Configuration
REQ-027 With ALU_ISSUE_ZFLAG_EN defined, SHALL add output zero_flag (1 bit, reset 0), updated in WB to (result == 0) and held otherwise.
REQ-028 Without ALU_ISSUE_ZFLAG_EN, the zero_flag port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package alu_issue_pkg SHALL hold DATA_W=8, OP_ADD=1'b0, OP_SHL=1'b1, the state enum (IDLE/EXEC/WB) and the instr field-extraction helpers.
REQ-030 The register file SHALL be sub-module alu_issue_rf: two async read ports, one write port with WB/load mux, async reset.
REQ-031 The ALU SHALL stay external; the parent connects alu_a/alu_b/alu_op/alu_result.

Verification
REQ-032 Load r1=10, r2=26; issue add r3=r1+r2 -> alu_a=10, alu_b=26, wb_valid 2 cycles after accept with wb_addr=3, wb_data=36; rf[3]=36.
REQ-033 Load r0=8'hFF, r1=3; issue shl r2=r0<<r1 -> wb_data=8'hF8; with r1=8 -> wb_data=0.
REQ-034 Load r1=200, r2=100; issue add -> wb_data=44 (wrap); with ZFLAG_EN, 128+128 -> wb_data=0, zero_flag=1.
REQ-035 Hold instr_valid high for 3 instructions -> accepts exactly 3 cycles apart; instr_ready low in EXEC/WB; load_valid in WB -> load_ready=0 and no write.
REQ-036 Assert rst_n low during EXEC of add r3 -> no wb_valid, rf[3]=0, all outputs at reset values; instr_ready returns 1 one edge after release.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: data width, opcodes,
// controller state encoding and instruction field extraction helpers.
package alu_issue_pkg;

  localparam int DATA_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SHL = 1'b1;

  // Helpers operate on a zero-extended instruction so they work for any
  // register-file depth up to 2**MAX_AW entries.
  localparam int MAX_AW      = 8;
  localparam int INSTR_MAX_W = 1 + 3 * MAX_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // Extract an aw-bit register index starting at bit lsb.
  function automatic logic [MAX_AW-1:0] instr_field(
    input logic [INSTR_MAX_W-1:0] ins,
    input int                     lsb,
    input int                     aw
  );
    logic [MAX_AW-1:0] f;
    f = '0;
    for (int i = 0; i < MAX_AW; i++) begin
      if (i < aw) f[i] = ins[lsb + i];
    end
    return f;
  endfunction

  // Instruction layout, LSB first: op, rs2, rs1, rd.
  function automatic logic instr_op(input logic [INSTR_MAX_W-1:0] ins);
    return ins[0];
  endfunction

  function automatic logic [MAX_AW-1:0] instr_rs2(
    input logic [INSTR_MAX_W-1:0] ins,
    input int                     aw
  );
    return instr_field(ins, 1, aw);
  endfunction

  function automatic logic [MAX_AW-1:0] instr_rs1(
    input logic [INSTR_MAX_W-1:0] ins,
    input int                     aw
  );
    return instr_field(ins, 1 + aw, aw);
  endfunction

  function automatic logic [MAX_AW-1:0] instr_rd(
    input logic [INSTR_MAX_W-1:0] ins,
    input int                     aw
  );
    return instr_field(ins, 1 + 2 * aw, aw);
  endfunction

endpackage

// File: rtl/alu_issue_rf.sv
// Register file for the ALU issue controller: two asynchronous read ports
// and a single write port shared between writeback and direct loads.
// Writeback and load never request the same edge because the controller
// withholds load_ready while a writeback is pending; writeback still wins
// the mux so a stray overlap cannot corrupt an instruction result.
module alu_issue_rf
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Select the write source: writeback over load.
  always_comb begin
    wr_en   = wb_en | ld_en;
    wr_addr = ld_addr;
    wr_data = ld_data;
    if (wb_en) begin
      wr_addr = wb_addr;
      wr_data = wb_data;
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller for an external 8-bit adder/shifter.
// Each instruction walks IDLE -> EXEC -> WB: operands are read and
// registered on accept, the ALU result is captured in EXEC, and WB
// registers the writeback report. The register-file write is driven by
// that registered report, so it lands one edge after WB, alongside the
// next possible accept. Operand reads at that accept see pre-edge contents,
// so an instruction issued back-to-back does not see its predecessor's
// result; issue sequences must be scheduled accordingly.
// Optional feature: define ALU_ISSUE_ZFLAG_EN to add the zero_flag output.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int RF_DEPTH = 4,
  localparam int AW      = $clog2(RF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [3*AW:0]     instr,
  output logic              instr_ready,
  input  logic              load_valid,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_addr,
  output logic [DATA_W-1:0] wb_data
`ifdef ALU_ISSUE_ZFLAG_EN
  ,
  output logic              zero_flag
`endif
);

  state_t            state;
  logic [AW-1:0]     rd_p0;
  logic [DATA_W-1:0] result_p1;

  logic [INSTR_MAX_W-1:0] instr_ext;
  logic [AW-1:0]          rs1_idx;
  logic [AW-1:0]          rs2_idx;
  logic [AW-1:0]          rd_idx;
  logic                   op_bit;
  logic [DATA_W-1:0]      rs1_data;
  logic [DATA_W-1:0]      rs2_data;
  logic                   accept;
  logic                   ld_en;

  assign instr_ext = INSTR_MAX_W'(instr);
  assign rs1_idx   = AW'(instr_rs1(instr_ext, AW));
  assign rs2_idx   = AW'(instr_rs2(instr_ext, AW));
  assign rd_idx    = AW'(instr_rd(instr_ext, AW));
  assign op_bit    = instr_op(instr_ext);

  assign accept = instr_valid && instr_ready;
  assign ld_en  = load_valid && load_ready;

  alu_issue_rf #(
    .DEPTH (RF_DEPTH),
    .AW    (AW)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rs1_idx),
    .rd_addr_b (rs2_idx),
    .rd_data_a (rs1_data),
    .rd_data_b (rs2_data),
    .wb_en     (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .ld_en     (ld_en),
    .ld_addr   (load_addr),
    .ld_data   (load_data)
  );

  // Issue FSM with registered handshakes, operands and writeback report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b0;
      load_ready  <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= OP_ADD;
      rd_p0       <= '0;
      result_p1   <= '0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
    end else begin
      case (state)
        // Stage p0: register operands and destination on accept.
        IDLE: begin
          wb_valid    <= 1'b0;
          load_ready  <= 1'b1;
          instr_ready <= 1'b1;
          if (accept) begin
            alu_a       <= rs1_data;
            alu_b       <= rs2_data;
            alu_op      <= op_bit;
            rd_p0       <= rd_idx;
            instr_ready <= 1'b0;
            state       <= EXEC;
          end
        end
        // Stage p1: capture the external ALU result.
        EXEC: begin
          wb_valid   <= 1'b0;
          load_ready <= 1'b1;
          result_p1  <= alu_result;
          state      <= WB;
        end
        // Stage p2: publish the writeback; the rf write follows from it.
        WB: begin
          wb_valid    <= 1'b1;
          wb_addr     <= rd_p0;
          wb_data     <= result_p1;
          load_ready  <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          wb_valid    <= 1'b0;
          instr_ready <= 1'b0;
          load_ready  <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_ZFLAG_EN
  // Zero flag tracks the most recent writeback result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
    end else if (state == WB) begin
      zero_flag <= (result_p1 == '0);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural adder/shifter model.
module tb_alu_issue_ctrl;

  localparam int RF_DEPTH = 4;
  localparam int AW       = 2;
  localparam int IW       = 1 + 3 * AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic          instr_ready;
  logic          load_valid;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          load_ready;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic          alu_op;
  logic [7:0]    alu_result;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [7:0]    wb_data;
`ifdef ALU_ISSUE_ZFLAG_EN
  logic          zero_flag;
`endif

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.RF_DEPTH(RF_DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .load_valid  (load_valid),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
`ifdef ALU_ISSUE_ZFLAG_EN
    ,
    .zero_flag   (zero_flag)
`endif
  );

  always #5 clk = ~clk;

  // External ALU: 8-bit add or logical shift left.
  always_comb begin
    alu_result = 8'(alu_a + alu_b);
    if (alu_op) alu_result = (alu_b >= 8'd8) ? 8'd0 : 8'(alu_a << alu_b[2:0]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rf_at(input logic [AW-1:0] i);
    return dut.u_rf.regs[i];
  endfunction

  function automatic logic [IW-1:0] mk(input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                                       input logic [AW-1:0] rs2, input logic op);
    return {rd, rs1, rs2, op};
  endfunction

  task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic run_instr(input logic [IW-1:0] ins, input logic [AW-1:0] rd,
                           input logic [7:0] exp_data, input string tag);
    int n;
    n = 0;
    while (!instr_ready && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = ins;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    chk({tag, "_wba"}, 32'(wb_addr), 32'(rd));
    chk({tag, "_wbd"}, 32'(wb_data), 32'(exp_data));
    tick();
    chk({tag, "_rf"}, 32'(rf_at(rd)), 32'(exp_data));
  endtask

  logic [IW-1:0] prog [3];
  logic          acc;
  int            idx;
  int            last;

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    load_valid  = 1'b0;
    load_addr   = '0;
    load_data   = '0;

    // Reset state
    tick();
    tick();
    chk("rst_iready", 32'(instr_ready), 32'd0);
    chk("rst_lready", 32'(load_ready), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_alua", 32'(alu_a), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_iready_pre", 32'(instr_ready), 32'd0);
    tick();
    chk("rel_iready", 32'(instr_ready), 32'd1);
    chk("rel_lready", 32'(load_ready), 32'd1);

    // add r3 = r1 + r2 with cycle-by-cycle timing
    load(2'd1, 8'd10);
    load(2'd2, 8'd26);
    instr_valid = 1'b1;
    instr       = mk(2'd3, 2'd1, 2'd2, 1'b0);
    tick();
    instr_valid = 1'b0;
    chk("add_alua", 32'(alu_a), 32'd10);
    chk("add_alub", 32'(alu_b), 32'd26);
    chk("add_op", 32'(alu_op), 32'd0);
    chk("add_busy", 32'(instr_ready), 32'd0);
    tick();
    chk("add_wbv_early", 32'(wb_valid), 32'd0);
    chk("add_busy2", 32'(instr_ready), 32'd0);
    tick();
    chk("add_wbv", 32'(wb_valid), 32'd1);
    chk("add_wba", 32'(wb_addr), 32'd3);
    chk("add_wbd", 32'(wb_data), 32'd36);
    chk("add_lready_wb", 32'(load_ready), 32'd0);
    chk("add_rf_pre", 32'(rf_at(2'd3)), 32'd0);
    load_valid = 1'b1;
    load_addr  = 2'd0;
    load_data  = 8'h55;
    tick();
    load_valid = 1'b0;
    chk("add_rf", 32'(rf_at(2'd3)), 32'd36);
    chk("wb_load_blocked", 32'(rf_at(2'd0)), 32'd0);
    chk("add_wbv_drop", 32'(wb_valid), 32'd0);
    chk("add_lready_back", 32'(load_ready), 32'd1);

    // shl r2 = r0 << r1 while r1 is reloaded at the accept edge
    load(2'd0, 8'hFF);
    load(2'd1, 8'd3);
    instr_valid = 1'b1;
    instr       = mk(2'd2, 2'd0, 2'd1, 1'b1);
    load_valid  = 1'b1;
    load_addr   = 2'd1;
    load_data   = 8'd8;
    tick();
    instr_valid = 1'b0;
    load_valid  = 1'b0;
    chk("shl_alua", 32'(alu_a), 32'hFF);
    chk("shl_alub_nofwd", 32'(alu_b), 32'd3);
    chk("shl_op", 32'(alu_op), 32'd1);
    chk("shl_load_r1", 32'(rf_at(2'd1)), 32'd8);
    tick();
    tick();
    chk("shl_wbd", 32'(wb_data), 32'hF8);
    tick();
    chk("shl_rf", 32'(rf_at(2'd2)), 32'hF8);
    run_instr(mk(2'd2, 2'd0, 2'd1, 1'b1), 2'd2, 8'd0, "shl8");

    // add wrap, with a load to rd during EXEC that the writeback overrides
    load(2'd1, 8'd200);
    load(2'd2, 8'd100);
    instr_valid = 1'b1;
    instr       = mk(2'd3, 2'd1, 2'd2, 1'b0);
    tick();
    instr_valid = 1'b0;
    load_valid  = 1'b1;
    load_addr   = 2'd3;
    load_data   = 8'h77;
    tick();
    load_valid = 1'b0;
    chk("exec_load", 32'(rf_at(2'd3)), 32'h77);
    tick();
    chk("wrap_wbd", 32'(wb_data), 32'd44);
`ifdef ALU_ISSUE_ZFLAG_EN
    chk("wrap_zf", 32'(zero_flag), 32'd0);
`endif
    tick();
    chk("wrap_rf", 32'(rf_at(2'd3)), 32'd44);

    load(2'd1, 8'd128);
    load(2'd2, 8'd128);
    run_instr(mk(2'd3, 2'd1, 2'd2, 1'b0), 2'd3, 8'd0, "zero");
`ifdef ALU_ISSUE_ZFLAG_EN
    chk("zero_zf", 32'(zero_flag), 32'd1);
`endif

    // Three instructions with instr_valid held high
    load(2'd1, 8'd5);
    load(2'd2, 8'd7);
    prog[0] = mk(2'd3, 2'd1, 2'd2, 1'b0);
    prog[1] = mk(2'd0, 2'd2, 2'd1, 1'b1);
    prog[2] = mk(2'd2, 2'd2, 2'd2, 1'b0);
    idx  = 0;
    last = 0;
    instr_valid = 1'b1;
    instr       = prog[0];
    for (int c = 0; c < 20 && idx < 3; c++) begin
      acc = instr_ready;
      tick();
      if (acc) begin
        if (idx > 0) chk("b2b_gap", 32'(c - last), 32'd3);
        chk("b2b_busy", 32'(instr_ready), 32'd0);
        last = c;
        idx++;
        if (idx < 3) instr = prog[idx];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    chk("b2b_count", 32'(idx), 32'd3);
    tick();
    tick();
    tick();
    chk("b2b_r3", 32'(rf_at(2'd3)), 32'd12);
    chk("b2b_r0", 32'(rf_at(2'd0)), 32'hE0);
    chk("b2b_r2_same", 32'(rf_at(2'd2)), 32'd14);

    // Reset during EXEC abandons the instruction
    instr_valid = 1'b1;
    instr       = mk(2'd3, 2'd1, 2'd2, 1'b0);
    tick();
    instr_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_iready", 32'(instr_ready), 32'd0);
    chk("ar_lready", 32'(load_ready), 32'd0);
    chk("ar_alua", 32'(alu_a), 32'd0);
    chk("ar_alub", 32'(alu_b), 32'd0);
    chk("ar_op", 32'(alu_op), 32'd0);
    chk("ar_wbd", 32'(wb_data), 32'd0);
    chk("ar_rf3", 32'(rf_at(2'd3)), 32'd0);
    tick();
    tick();
    chk("ar_wbv_hold", 32'(wb_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ar_rel_pre", 32'(instr_ready), 32'd0);
    tick();
    chk("ar_rel_iready", 32'(instr_ready), 32'd1);
    chk("ar_rel_lready", 32'(load_ready), 32'd1);
    tick();
    tick();
    chk("ar_no_wb", 32'(wb_valid), 32'd0);
    chk("ar_rf3_after", 32'(rf_at(2'd3)), 32'd0);
`ifdef ALU_ISSUE_ZFLAG_EN
    chk("ar_zf", 32'(zero_flag), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
